// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl
//  Description : 4-digit 7-segment scan controller with per-digit blanking,
//                8-level PWM brightness, and a frame-timed buzzer sequencer
//                accepting beep requests over a req/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 50000,  // clocks per digit slot (multiple of 8, >= 16)
  parameter int BEEP_DIV = 25000   // clocks per buzzer half-period (>= 1)
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] seg_data,
  input  logic [3:0]  blank,
  input  logic [2:0]  bright,
  input  logic        beep_req,
  input  logic [7:0]  beep_len,
  output logic        beep_ack,
  output logic        beep_busy,
  output logic        frame_tick,
  output logic [0:3]  SD,
  output logic [0:7]  SEG,
  output logic        Buzz
);

  localparam int TICKS  = SCAN_DIV / 8;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int TONE_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS - 1);
  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(BEEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    COOL = 2'd2
  } state_t;

  logic [TICK_W-1:0] tick;
  logic [2:0]        phase;
  logic [1:0]        digit;
  logic [7:0]        shadow;

  state_t            state;
  logic [7:0]        remaining;
  logic [TONE_W-1:0] tone_cnt;

  logic              slot_start;
  logic              frame_end;
  logic [7:0]        cur_pat;
  logic [7:0]        pat;
  logic              lit;

  // The first cycle of a slot uses the live input so the new digit never
  // shows the previous digit's pattern while the shadow is being loaded.
  assign slot_start = (tick == '0) && (phase == 3'd0);
  assign frame_end  = (digit == 2'd3) && (phase == 3'd7) && (tick == TICK_MAX);
  assign cur_pat    = seg_data[{digit, 3'b000} +: 8];
  assign pat        = slot_start ? cur_pat : shadow;
  assign lit        = (phase < bright) && !blank[digit];

  // Free-running tick -> phase -> digit scan counters
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tick  <= '0;
      phase <= 3'd0;
      digit <= 2'd0;
    end else if (tick == TICK_MAX) begin
      tick <= '0;
      if (phase == 3'd7) begin
        phase <= 3'd0;
        digit <= digit + 2'd1;
      end else begin
        phase <= phase + 3'd1;
      end
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Capture the selected digit's pattern once at the start of each slot
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadow <= 8'hFF;
    end else if (slot_start) begin
      shadow <= cur_pat;
    end
  end

  // Registered pin drive and end-of-frame pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      SD         <= 4'b1111;
      SEG        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      SD         <= 4'b1111;
      SEG        <= 8'hFF;
      frame_tick <= frame_end;
      if (lit) begin
        SD[digit] <= 1'b0;
        for (int k = 0; k < 8; k++) begin
          SEG[k] <= pat[k];
        end
      end
    end
  end

  // Beep sequencer: accept in IDLE, tone for beep_len frames, cool one frame
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      remaining <= 8'd0;
      tone_cnt  <= '0;
      beep_ack  <= 1'b0;
      beep_busy <= 1'b0;
      Buzz      <= 1'b0;
    end else begin
      beep_ack <= 1'b0;
      case (state)
        IDLE: begin
          Buzz <= 1'b0;
          if (beep_req) begin
            beep_ack  <= 1'b1;
            remaining <= beep_len;
            if (beep_len != 8'd0) begin
              state     <= TONE;
              beep_busy <= 1'b1;
              Buzz      <= 1'b1;
              tone_cnt  <= '0;
            end
          end
        end
        TONE: begin
          if (frame_tick && (remaining <= 8'd1)) begin
            state     <= COOL;
            remaining <= 8'd0;
            Buzz      <= 1'b0;
          end else begin
            if (frame_tick) begin
              remaining <= remaining - 8'd1;
            end
            if (tone_cnt == TONE_MAX) begin
              tone_cnt <= '0;
              Buzz     <= ~Buzz;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        COOL: begin
          Buzz <= 1'b0;
          if (frame_tick) begin
            state     <= IDLE;
            beep_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          beep_busy <= 1'b0;
          Buzz      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan and sequencing controller for the 4-digit 7-segment display and the buzzer on the Output side of the calculator. It time-multiplexes four digits onto the shared SD/SEG pins, applies per-digit blanking and 8-level PWM brightness, and runs a beep-length sequencer. The beep sequencer takes requests over a req/ack handshake. The block sits between the Output module's decoded data and the board pins.

Parameters:
SCAN_DIV, 50000, clocks per digit slot; must be a multiple of 8 and at least 16
BEEP_DIV, 25000, clocks per half-period of the buzzer tone; must be at least 1

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
seg_data  in  32  raw segment patterns, active-low; digit i uses seg_data[8i+7:8i], bit 0 is segment a, bit 7 is dp
blank  in  4  blank[i]=1 keeps digit i dark
bright  in  3  duty level 0..7; 0 means display off
beep_req  in  1  level request to start a beep
beep_len  in  8  beep length in scan frames; sampled at acceptance
beep_ack  out  1  one-cycle pulse when a request is accepted
beep_busy  out  1  high while the sequencer is not IDLE
frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame
SD  out  [0:3]  digit enables, active-low; SD[i] selects digit i
SEG  out  [0:7]  segment drive, active-low; SEG[k] is seg_data bit k of the selected digit
Buzz  out  1  buzzer drive

Behaviour:
- Reset (Reset=0, asynchronous): SD=4'b1111, SEG=8'hFF, Buzz=0, beep_ack=0, beep_busy=0, frame_tick=0. All counters clear to 0 and the FSM goes to IDLE.
- Scan counters: tick 0..SCAN_DIV/8-1, phase 0..7, digit 0..3, all free-running. Frame period is 4*SCAN_DIV clocks.
  - tick wraps, then phase increments.
  - phase wraps, then digit increments; digit 3 wraps to 0.
- Segment snapshot: seg_data[8*digit+7:8*digit] is captured into a shadow register when tick=0 and phase=0. Changes to seg_data mid-slot take effect at the next slot only.
- Lit condition: phase < bright AND blank[digit]=0. Phase 7 is therefore always dark (anti-ghost gap).
  - Lit: SD has only bit [digit] low; SEG = shadow.
  - Dark: SD=4'b1111 and SEG=8'hFF.
- Output timing: SD and SEG are registered. They reflect the counter state of the previous clock, giving 1 cycle of latency. SD and SEG always change on the same edge.
- frame_tick: registered, high for exactly 1 cycle. It follows the cycle where digit=3, phase=7 and tick is at its maximum.
- Beep FSM states: IDLE, TONE, COOL.
  - IDLE with beep_req=1: beep_ack pulses for 1 cycle and beep_len is latched into remaining.
  - If beep_len=0: stay in IDLE, Buzz stays 0, beep_busy stays 0.
  - Otherwise: go to TONE on the next clock.
  - TONE: a tone counter toggles Buzz every BEEP_DIV clocks; Buzz starts at 1 on TONE entry.
  - TONE: each frame_tick strictly after the acceptance cycle decrements remaining. When remaining reaches 0, go to COOL and force Buzz=0.
  - COOL: Buzz=0. The next frame_tick returns the FSM to IDLE.
  - beep_busy=1 in TONE and COOL.
  - beep_req while busy is ignored: no ack and no queueing. A held request is accepted on the first IDLE cycle.
- Tone length: between beep_len-1 and beep_len frames, because frame phase is not aligned to acceptance.
- bright and blank are sampled every cycle; changes take effect with 1-cycle latency.

Test Plan:
- SCAN_DIV=16, bright=7, blank=0, seg_data=32'h01234567: SD=0111 with SEG=8'h67 for 14 clocks, then 1111/FF for 2 clocks, then SD=1011 with SEG=8'h45. frame_tick pulses every 64 clocks.
- bright=2: each digit is lit for exactly 4 of 16 clocks. bright=0: SD stays 1111 for a full frame.
- blank=4'b0100: SD[2] never low over 3 frames; the other digits are unaffected.
- seg_data changes from 32'h01234567 to 32'hFFFFFF00 at clock 5 of digit 0's slot: SEG stays 8'h67 until the slot ends. Digit 0 shows 8'h00 from the next frame.
- BEEP_DIV=3, beep_len=2, beep_req held: beep_ack high 1 cycle and beep_busy rises. Buzz toggles every 3 clocks and ends at the 2nd counted frame_tick. beep_busy falls 1 frame later. A second beep_req during busy gets no ack.
- beep_len=0 accepted gives an ack pulse, beep_busy=0 and Buzz=0. Reset pulled low mid-TONE drives Buzz=0 and SD=1111 immediately, before any clock edge.
